// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard detection: EXE/MEM destination compare for NUM_SRC operands plus a
// per-register pending-load scoreboard. Define HAZARD_WATCHDOG_EN to build the stall watchdog.
module hazard_scoreboard_unit #(
  parameter int REG_AW      = 4,
  parameter int NUM_SRC     = 2,
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] src,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic                      ignore_hazard,
  input  logic                      forwarding_en,
  input  logic [REG_AW-1:0]         exe_dest,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic                      exe_wb_en,
  input  logic                      mem_wb_en,
  input  logic                      exe_mem_r_en,
  input  logic                      pipe_freeze,
  input  logic                      ld_done,
  input  logic [REG_AW-1:0]         ld_done_dest,
  output logic                      hazard_detected,
  output logic [(1<<REG_AW)-1:0]    pending,
  output logic [CNT_W-1:0]          stall_count,
  output logic                      stall_timeout
);

  if (STALL_LIMIT < 1 || STALL_LIMIT >= (1 << CNT_W)) begin : g_bad_limit
    $error("STALL_LIMIT must lie in 1..2^CNT_W-1");
  end

  logic [NUM_SRC-1:0]         match_exe;
  logic [NUM_SRC-1:0]         match_mem;
  logic [NUM_SRC-1:0]         match_pend;
  logic                       exe_ld_hit;
  logic                       ld_issue;
  logic [(1<<REG_AW)-1:0]     pending_next;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] addr;
    assign addr          = src[i*REG_AW +: REG_AW];
    assign match_exe[i]  = src_valid[i] & (addr == exe_dest) & exe_wb_en;
    assign match_mem[i]  = src_valid[i] & (addr == mem_dest) & mem_wb_en;
    assign match_pend[i] = src_valid[i] & pending[addr];
  end

  assign exe_ld_hit = (|match_exe) & exe_mem_r_en;

  // With forwarding, only a load still in flight (EXE or scoreboard) forces a stall.
  always_comb begin
    hazard_detected = 1'b0;
    if (!ignore_hazard) begin
      if (forwarding_en) hazard_detected = exe_ld_hit | (|match_pend);
      else               hazard_detected = (|match_exe) | (|match_mem) | (|match_pend);
    end
  end

  assign ld_issue = exe_mem_r_en & exe_wb_en & ~pipe_freeze;

  // NOTE: set is applied after clear so a new load to the same register wins over the
  // older returning one; defaulting to the current value first keeps this block latch-free.
  always_comb begin
    pending_next = pending;
    if (ld_done)  pending_next[ld_done_dest] = 1'b0;
    if (ld_issue) pending_next[exe_dest]     = 1'b1;
  end

  // NOTE: the scoreboard is reset (unlike a data RAM) because a stale pending bit would
  // stall its consumer forever; non-blocking assignment keeps state updates edge-ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

`ifdef HAZARD_WATCHDOG_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = stall_count;
    if (!pipe_freeze) begin
      if (!hazard_detected)          count_next = '0;
      else if (stall_count != CNT_MAX) count_next = stall_count + CNT_W'(1);
    end
  end

  // The flag is taken from the next count so it rises together with the limit value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count   <= '0;
      stall_timeout <= 1'b0;
    end else begin
      stall_count <= count_next;
      if (count_next >= LIMIT) stall_timeout <= 1'b1;
    end
  end
`else
  assign stall_count   = '0;
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed self-checking bench for hazard_scoreboard_unit (STALL_LIMIT = 4); watchdog
// expectations follow HAZARD_WATCHDOG_EN.
module tb_hazard_scoreboard_unit;
  localparam int REG_AW = 4;
  localparam int NUM_SRC = 2;
  localparam int CNT_W = 8;
`ifdef HAZARD_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic                      clk, rst;
  logic [NUM_SRC*REG_AW-1:0] src;
  logic [NUM_SRC-1:0]        src_valid;
  logic                      ignore_hazard, forwarding_en;
  logic [REG_AW-1:0]         exe_dest, mem_dest, ld_done_dest;
  logic                      exe_wb_en, mem_wb_en, exe_mem_r_en, pipe_freeze, ld_done;
  logic                      hazard_detected;
  logic [15:0]               pending;
  logic [CNT_W-1:0]          stall_count;
  logic                      stall_timeout;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .STALL_LIMIT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src(src), .src_valid(src_valid),
    .ignore_hazard(ignore_hazard), .forwarding_en(forwarding_en),
    .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .pipe_freeze(pipe_freeze), .ld_done(ld_done),
    .ld_done_dest(ld_done_dest), .hazard_detected(hazard_detected), .pending(pending),
    .stall_count(stall_count), .stall_timeout(stall_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL time_limit: simulation did not reach summary, required finish before 500us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src = '0; src_valid = '0; ignore_hazard = 1'b0; forwarding_en = 1'b0;
    exe_dest = '0; mem_dest = '0; exe_wb_en = 1'b0; mem_wb_en = 1'b0;
    exe_mem_r_en = 1'b0; pipe_freeze = 1'b0; ld_done = 1'b0; ld_done_dest = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_hz(input string name, input logic exp);
    checks++;
    if (hazard_detected !== exp) begin
      $display("FAIL %s: hazard_detected=%b expected=%b", name, hazard_detected, exp);
      errors++;
    end
  endtask

  task automatic chk_pend(input string name, input logic [15:0] exp);
    checks++;
    if (pending !== exp) begin
      $display("FAIL %s: pending=%h expected=%h", name, pending, exp);
      errors++;
    end
  endtask

  task automatic chk_wd(input string name, input logic [CNT_W-1:0] exp_cnt, input logic exp_to);
    checks++;
    if (stall_count !== exp_cnt || stall_timeout !== exp_to) begin
      $display("FAIL %s: stall_count=%0d stall_timeout=%b expected count=%0d timeout=%b",
               name, stall_count, stall_timeout, exp_cnt, exp_to);
      errors++;
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #12;
    chk_pend("reset_pending", 16'h0000);
    chk_wd("reset_watchdog", '0, 1'b0);
    chk_hz("reset_hazard", 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_compare();
    tick();
    src[3:0] = 4'd3; src_valid = 2'b01; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1 chk_hz("exe_match_nofwd", 1'b1);
    src_valid[0] = 1'b0;
    #1 chk_hz("src_invalid", 1'b0);
    src_valid[0] = 1'b1; ignore_hazard = 1'b1;
    #1 chk_hz("ignore_hazard", 1'b0);
    ignore_hazard = 1'b0; exe_wb_en = 1'b0;
    #1 chk_hz("exe_wb_off", 1'b0);
    src[7:4] = 4'd6; src_valid = 2'b11; mem_dest = 4'd6; mem_wb_en = 1'b1;
    #1 chk_hz("mem_match_nofwd", 1'b1);
    forwarding_en = 1'b1;
    #1 chk_hz("mem_match_fwd", 1'b0);
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; pipe_freeze = 1'b1;
    #1 chk_hz("exe_load_fwd", 1'b1);
    idle();
    tick();
    forwarding_en = 1'b1; src[7:4] = 4'd3; src_valid = 2'b10; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1 chk_hz("exe_alu_fwd", 1'b0);
    chk_pend("compare_no_pending", 16'h0000);
    idle();
  endtask

  task automatic test_load_pending();
    tick();
    forwarding_en = 1'b1; src[7:4] = 4'd5; src_valid = 2'b10;
    exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1 chk_hz("ld_in_exe", 1'b1);
    tick();
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = 4'd0;
    #1 chk_pend("ld_pending_set", 16'h0020);
    chk_hz("ld_wait1", 1'b1);
    tick();
    #1 chk_hz("ld_wait2", 1'b1);
    tick();
    ld_done = 1'b1; ld_done_dest = 4'd5;
    #1 chk_hz("ld_done_cycle", 1'b1);
    chk_pend("ld_done_cycle_pending", 16'h0020);
    tick();
    ld_done = 1'b0;
    #1 chk_hz("ld_after_done", 1'b0);
    chk_pend("ld_cleared", 16'h0000);
    idle();
  endtask

  task automatic test_same_cycle();
    tick();
    exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; ld_done = 1'b1; ld_done_dest = 4'd7;
    tick();
    #1 chk_pend("set_wins", 16'h0080);
    exe_dest = 4'd2;
    tick();
    #1 chk_pend("set_clear_diff", 16'h0004);
    exe_dest = 4'd4; pipe_freeze = 1'b1; ld_done_dest = 4'd2;
    tick();
    #1 chk_pend("freeze_blocks_set", 16'h0000);
    exe_mem_r_en = 1'b0; exe_wb_en = 1'b0; pipe_freeze = 1'b0; ld_done_dest = 4'd11;
    tick();
    #1 chk_pend("clear_not_pending", 16'h0000);
    idle();
  endtask

  task automatic test_watchdog();
    pulse_reset();
    idle();
    tick();
    src[3:0] = 4'd3; src_valid = 2'b01; exe_dest = 4'd3; exe_wb_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      #1 chk_wd($sformatf("stall_cycle%0d", k), WD ? CNT_W'(k) : '0, WD ? (k >= 4) : 1'b0);
    end
    idle();
    tick();
    #1 chk_wd("stall_removed", '0, WD);
    src[3:0] = 4'd3; src_valid = 2'b01; exe_dest = 4'd3; exe_wb_en = 1'b1;
    tick();
    pipe_freeze = 1'b1;
    tick();
    tick();
    #1 chk_wd("freeze_hold", WD ? CNT_W'(1) : '0, WD);
    pipe_freeze = 1'b0;
    repeat (300) tick();
    #1 chk_wd("saturate", WD ? CNT_W'(255) : '0, WD);
    idle();
    pulse_reset();
    #1 chk_wd("watchdog_reset", '0, 1'b0);
  endtask

  task automatic test_reset_midload();
    tick();
    exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd1;
    tick();
    exe_dest = 4'd2;
    tick();
    exe_dest = 4'd9;
    tick();
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = 4'd0;
    forwarding_en = 1'b1; src[3:0] = 4'd9; src_valid = 2'b01;
    #1 chk_pend("three_pending", 16'h0206);
    chk_hz("pending_r9_hazard", 1'b1);
    #1 rst = 1'b1;
    #1 chk_pend("async_reset_pending", 16'h0000);
    chk_hz("async_reset_hazard", 1'b0);
    chk_wd("async_reset_watchdog", '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_compare();
    test_load_pending();
    test_same_cycle();
    test_watchdog();
    test_reset_midload();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised hazard detection for the ARM pipeline's ID stage. It generalises the EXE/MEM destination-compare hazard check to `NUM_SRC` source operands. It also adds a per-register pending-load scoreboard for variable-latency data memory, so a consumer stalls until its load has actually returned, not only while the load sits in EXE. The `hazard_detected` output drives IF/ID freeze and EXE bubble insertion.

## Interface
- `REG_AW`, 4, register address width; scoreboard holds 2^REG_AW pending bits.
- `NUM_SRC`, 2, number of source operands checked per instruction.
- `STALL_LIMIT`, 64, consecutive stall cycles before `stall_timeout` sets (1..2^CNT_W-1).
- `CNT_W`, 8, width of `stall_count`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `src`  in  NUM_SRC*REG_AW  ID source addresses; source i at `[i*REG_AW +: REG_AW]`.
- `src_valid`  in  NUM_SRC  per-source use flag; an unused source never hazards.
- `ignore_hazard`  in  1  ID instruction has no register dependencies.
- `forwarding_en`  in  1  forwarding unit active.
- `exe_dest`, `mem_dest`  in  REG_AW  destination addresses in EXE and MEM.
- `exe_wb_en`, `mem_wb_en`  in  1  write-back enables of EXE and MEM.
- `exe_mem_r_en`  in  1  instruction in EXE is a load.
- `pipe_freeze`  in  1  whole pipeline held by memory; EXE does not advance.
- `ld_done`  in  1  load data returned and written this cycle.
- `ld_done_dest`  in  REG_AW  register written by the returning load.
- `hazard_detected`  out  1  stall ID this cycle (combinational).
- `pending`  out  2^REG_AW  scoreboard bits (registered).
- `stall_count`  out  CNT_W  consecutive-stall counter (registered).
- `stall_timeout`  out  1  sticky watchdog flag (registered).

## Operation
- Per source i, `match_X[i] = src_valid[i] & (src_i == X_dest) & X_wb_en`, for X ∈ {exe, mem}.
- Per source i, `match_P[i] = src_valid[i] & pending[src_i]`.
- `exe_ld_hit` = OR over i of `match_exe[i] & exe_mem_r_en`.
- `hazard_detected`:
  - 0 if `ignore_hazard`.
  - Else, with `forwarding_en`: `exe_ld_hit | OR(match_P)`.
  - Else: `OR(match_exe) | OR(match_mem) | OR(match_P)`.
- Scoreboard set: when `exe_mem_r_en & exe_wb_en & ~pipe_freeze`, `pending[exe_dest]` ← 1 at the next edge.
- Scoreboard clear: when `ld_done`, `pending[ld_done_dest]` ← 0 at the next edge.
- Set and clear of the same register in the same cycle: set wins, because the returning load is older than the newly issued one.
- Clear of a bit that is not pending: no effect.
- `pipe_freeze` does not block clears.
- Stall counter:
  - `hazard_detected` = 1: increment, saturating at 2^CNT_W-1.
  - `hazard_detected` = 0: reset to 0.
  - `pipe_freeze` = 1: hold the current value.
- `stall_timeout` sets when `stall_count` reaches `STALL_LIMIT`. It clears only on `rst`.

## Timing
- `rst` asserted: `pending` = 0, `stall_count` = 0, `stall_timeout` = 0 immediately, without waiting for a clock edge. `hazard_detected` then follows the compare terms only.
- `hazard_detected` is zero-latency from its inputs.
- `pending` updates one cycle after issue. A consumer is therefore covered by `exe_ld_hit` while the load is in EXE, then by the `pending` bit until one cycle after `ld_done`.
- `pending` is cleared at the edge ending the `ld_done` cycle. The consumer's `hazard_detected` drops in the following cycle; there is no same-cycle bypass.
- A reset that arrives mid-load drops all pending bits. Any in-flight load is discarded by the pipeline.

## Configuration
- `HAZARD_WATCHDOG_EN` defined: `stall_count` and `stall_timeout` are implemented as specified above.
- `HAZARD_WATCHDOG_EN` undefined: the counter and flag registers are not built, and both outputs are tied to 0. The hazard and scoreboard behaviour is identical in both builds.

## Test plan
- Defaults, `forwarding_en` = 0, src0 = 3 valid, `exe_dest` = 3, `exe_wb_en` = 1 → `hazard_detected` = 1. Set `src_valid[0]` = 0 → 0. Set `ignore_hazard` = 1 → 0.
- `forwarding_en` = 1, load to r5 issued from EXE, `ld_done` 3 cycles later, consumer src1 = 5 → `hazard_detected` = 1 in the EXE cycle and until one cycle after `ld_done`; `pending[5]` = 0 afterwards.
- Same cycle: issue load r7 and `ld_done` r7 → `pending[7]` = 1. Issue a load with `pipe_freeze` = 1 → `pending` unchanged.
- `STALL_LIMIT` = 4, hazard held 6 cycles → `stall_count` reads 1..6 and `stall_timeout` = 1 from count 4. Remove the hazard → count = 0 while the flag stays 1. Without `HAZARD_WATCHDOG_EN` → both outputs read 0.
- Three loads pending (r1, r2, r9), assert `rst` between edges → `pending` = 0 immediately; src = 9 → `hazard_detected` = 0.
